// File: rtl/uart_rx_frame_decoder.sv
// UART receive decoder: start, 8 data bits LSB-first, parity slot, stop.
// Oversampled line with 3-sample majority vote and a valid/ready output register.
//
// state    | meaning
// S_IDLE   | waiting for a synchronized falling edge
// S_START  | start bit; a high decision means a glitch
// S_DATA   | eight data bits shifted in LSB-first
// S_PARITY | parity slot decision
// S_STOP   | stop decision, then word delivery
module uart_rx_frame_decoder #(
    parameter int OVERSAMPLE      = 16,
    parameter int CLKS_PER_SAMPLE = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       parity_en,
    input  logic       rx_uart,
    output logic       rx_data_valid,
    input  logic       rx_data_ready,
    output logic [7:0] rx_data,
    output logic       rx_parity_error,
    output logic       rx_frame_error,
    output logic       rx_overrun
);

    localparam int M     = OVERSAMPLE / 2;
    localparam int IDX_W = $clog2(OVERSAMPLE);
    localparam int DIV_W = (CLKS_PER_SAMPLE > 1) ? $clog2(CLKS_PER_SAMPLE) : 1;

    localparam logic [IDX_W-1:0] IDX_PRE  = IDX_W'(M - 1);
    localparam logic [IDX_W-1:0] IDX_MID  = IDX_W'(M);
    localparam logic [IDX_W-1:0] IDX_DEC  = IDX_W'(M + 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(OVERSAMPLE - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_SAMPLE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t           state_q;
    logic             sync1_q;
    logic             sync2_q;
    logic             prev_q;
    logic [DIV_W-1:0] div_q;
    logic [IDX_W-1:0] idx_q;
    logic [2:0]       bit_cnt_q;
    logic [1:0]       smp_q;
    logic [7:0]       shift_q;
    logic             par_en_q;
    logic             par_err_q;
    logic             valid_q;
    logic [7:0]       data_q;
    logic             perr_q;
    logic             ferr_q;
    logic             ovr_q;

    logic start_edge_d;
    logic tick_d;
    logic decide_d;
    logic bit_end_d;
    logic bit_d;
    logic load_d;
    logic xfer_d;

    always_comb begin
        start_edge_d = (state_q == S_IDLE) && prev_q && !sync2_q;
        tick_d       = (div_q == DIV_LAST);
        decide_d     = tick_d && (state_q != S_IDLE) && (idx_q == IDX_DEC);
        bit_end_d    = tick_d && (state_q != S_IDLE) && (idx_q == IDX_LAST);
        bit_d        = (smp_q[0] & smp_q[1]) | (smp_q[0] & sync2_q) | (smp_q[1] & sync2_q);
        load_d       = decide_d && (state_q == S_STOP);
        xfer_d       = valid_q && rx_data_ready;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            prev_q    <= 1'b1;
            div_q     <= '0;
            idx_q     <= '0;
            bit_cnt_q <= '0;
            smp_q     <= '0;
            shift_q   <= '0;
            par_en_q  <= 1'b0;
            par_err_q <= 1'b0;
            valid_q   <= 1'b0;
            data_q    <= '0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            sync1_q <= rx_uart;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;

            if (start_edge_d || tick_d) begin
                div_q <= '0;
            end else begin
                div_q <= div_q + DIV_W'(1);
            end

            if (state_q == S_IDLE) begin
                if (start_edge_d) begin
                    state_q   <= S_START;
                    idx_q     <= '0;
                    bit_cnt_q <= '0;
                    par_en_q  <= parity_en;
                    par_err_q <= 1'b0;
                end
            end else if (tick_d) begin
                if (idx_q == IDX_PRE) smp_q[0] <= sync2_q;
                if (idx_q == IDX_MID) smp_q[1] <= sync2_q;
                idx_q <= (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);

                if (decide_d) begin
                    case (state_q)
                        S_START:  if (bit_d) state_q <= S_IDLE;
                        S_DATA:   shift_q <= {bit_d, shift_q[7:1]};
                        S_PARITY: par_err_q <= par_en_q & (bit_d ^ (^shift_q));
                        // Leave mid-stop so the next start edge is caught on time.
                        S_STOP:   state_q <= S_IDLE;
                        default:  ;
                    endcase
                end

                if (bit_end_d) begin
                    case (state_q)
                        S_START:  state_q <= S_DATA;
                        S_DATA: begin
                            if (bit_cnt_q == 3'd7) begin
                                state_q <= S_PARITY;
                            end else begin
                                bit_cnt_q <= bit_cnt_q + 3'd1;
                            end
                        end
                        S_PARITY: state_q <= S_STOP;
                        default:  ;
                    endcase
                end
            end

            if (load_d) begin
                valid_q <= 1'b1;
                data_q  <= shift_q;
                perr_q  <= par_err_q;
                ferr_q  <= ~bit_d;
                ovr_q   <= valid_q && !rx_data_ready;
            end else if (xfer_d) begin
                valid_q <= 1'b0;
                perr_q  <= 1'b0;
                ferr_q  <= 1'b0;
                ovr_q   <= 1'b0;
            end
        end
    end

    assign rx_data_valid   = valid_q;
    assign rx_data         = data_q;
    assign rx_parity_error = perr_q;
    assign rx_frame_error  = ferr_q;
    assign rx_overrun      = ovr_q;

endmodule

// File: tb/tb_uart_rx_frame_decoder.sv
// Directed and randomized frames against a line-level frame model and
// parity/stop rules; received words are captured on each valid/ready transfer.
module tb_uart_rx_frame_decoder;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       parity_en = 1'b1;
    logic       rx_uart = 1'b1;
    logic       rx_data_ready = 1'b1;
    logic       rx_data_valid;
    logic [7:0] rx_data;
    logic       rx_parity_error;
    logic       rx_frame_error;
    logic       rx_overrun;

    int total = 0;
    int bad = 0;
    int valid_cycles = 0;
    logic [10:0] got_q[$];

    uart_rx_frame_decoder #(.OVERSAMPLE(16), .CLKS_PER_SAMPLE(1)) dut (
        .clk             (clk),
        .reset           (reset),
        .parity_en       (parity_en),
        .rx_uart         (rx_uart),
        .rx_data_valid   (rx_data_valid),
        .rx_data_ready   (rx_data_ready),
        .rx_data         (rx_data),
        .rx_parity_error (rx_parity_error),
        .rx_frame_error  (rx_frame_error),
        .rx_overrun      (rx_overrun)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!reset) begin
            if (rx_data_valid) valid_cycles++;
            if (rx_data_valid && rx_data_ready)
                got_q.push_back({rx_data, rx_parity_error, rx_frame_error, rx_overrun});
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Line level at clock c of a frame: 16 clocks per slot.
    function automatic logic line_level(input logic [7:0] d, input logic pbit,
                                        input logic sbit, input int c);
        int slot;
        slot = c / 16;
        if (slot == 0) return 1'b0;
        if (slot <= 8) return d[slot-1];
        if (slot == 9) return pbit;
        return sbit;
    endfunction

    function automatic logic exp_perr(input logic pen, input logic [7:0] d, input logic pbit);
        logic even_ones;
        even_ones = ($countones(d) % 2) == 0;
        return pen && (pbit != !even_ones);
    endfunction

    function automatic logic even_bit(input logic [7:0] d);
        return logic'($countones(d) % 2);
    endfunction

    task automatic send_frame(input logic [7:0] d, input logic pbit, input logic sbit,
                              input int glitch_at, input bit flip_pen);
        for (int c = 0; c < 176; c++) begin
            cyc();
            rx_uart = line_level(d, pbit, sbit, c) ^ (c == glitch_at);
            if (flip_pen && c == 80) parity_en = ~parity_en;
        end
        cyc();
    endtask

    task automatic expect_word(input string tag, input logic [7:0] d, input logic pe,
                               input logic fe, input logic ov);
        logic [10:0] w;
        for (int i = 0; i < 60 && got_q.size() == 0; i++) cyc();
        total++;
        assert (got_q.size() > 0) else begin
            bad++;
            $error("FAIL %s_timeout: observed=no word expected=word", tag);
        end
        if (got_q.size() > 0) begin
            w = got_q.pop_front();
            check({tag, "_data"}, 32'(w[10:3]), 32'(d));
            check({tag, "_flags"}, 32'(w[2:0]), 32'({pe, fe, ov}));
        end
    endtask

    initial begin
        int v0;
        logic [7:0] d;
        logic pen, pbit, sbit;
        bit flip;

        repeat (3) cyc();
        reset = 1'b0;
        @(negedge clk);
        check("rst_valid", 32'(rx_data_valid), 32'd0);
        check("rst_data", 32'(rx_data), 32'h00);
        check("rst_flags", 32'({rx_parity_error, rx_frame_error, rx_overrun}), 32'd0);

        v0 = valid_cycles;
        send_frame(8'hA5, 1'b0, 1'b1, -1, 1'b0);
        expect_word("a5_good", 8'hA5, 1'b0, 1'b0, 1'b0);
        repeat (5) cyc();
        check("a5_valid_len", 32'(valid_cycles - v0), 32'd1);

        send_frame(8'hA5, 1'b1, 1'b1, -1, 1'b0);
        expect_word("a5_badpar", 8'hA5, exp_perr(1'b1, 8'hA5, 1'b1), 1'b0, 1'b0);
        parity_en = 1'b0;
        send_frame(8'hA5, 1'b1, 1'b1, -1, 1'b0);
        expect_word("a5_nopar", 8'hA5, 1'b0, 1'b0, 1'b0);
        parity_en = 1'b1;

        send_frame(8'h3C, 1'b0, 1'b0, -1, 1'b0);
        repeat (16) cyc();
        rx_uart = 1'b1;
        expect_word("3c_ferr", 8'h3C, 1'b0, 1'b1, 1'b0);
        repeat (10) cyc();
        send_frame(8'h81, 1'b0, 1'b1, -1, 1'b0);
        expect_word("81_after", 8'h81, 1'b0, 1'b0, 1'b0);

        v0 = valid_cycles;
        rx_uart = 1'b0;
        repeat (4) cyc();
        rx_uart = 1'b1;
        repeat (40) cyc();
        check("glitch_words", 32'(got_q.size()), 32'd0);
        check("glitch_valid", 32'(valid_cycles - v0), 32'd0);
        send_frame(8'hFF, 1'b0, 1'b1, 56, 1'b0);
        expect_word("ff_glitch", 8'hFF, 1'b0, 1'b0, 1'b0);

        rx_data_ready = 1'b0;
        send_frame(8'h11, 1'b0, 1'b1, -1, 1'b0);
        @(negedge clk);
        check("ovr1_valid", 32'(rx_data_valid), 32'd1);
        check("ovr1_data", 32'(rx_data), 32'h11);
        check("ovr1_ovr", 32'(rx_overrun), 32'd0);
        send_frame(8'h22, 1'b0, 1'b1, -1, 1'b0);
        @(negedge clk);
        check("ovr2_valid", 32'(rx_data_valid), 32'd1);
        check("ovr2_data", 32'(rx_data), 32'h22);
        check("ovr2_ovr", 32'(rx_overrun), 32'd1);
        cyc();
        rx_data_ready = 1'b1;
        cyc();
        rx_data_ready = 1'b0;
        @(negedge clk);
        check("ovr_acc_valid", 32'(rx_data_valid), 32'd0);
        check("ovr_acc_ovr", 32'(rx_overrun), 32'd0);
        expect_word("ovr_word", 8'h22, 1'b0, 1'b0, 1'b1);
        rx_data_ready = 1'b1;

        for (int c = 0; c < 16 * 4 + 6; c++) begin
            cyc();
            rx_uart = line_level(8'hC3, 1'b0, 1'b1, c);
        end
        cyc();
        reset = 1'b1;
        rx_uart = 1'b1;
        cyc();
        reset = 1'b0;
        @(negedge clk);
        check("mid_rst_valid", 32'(rx_data_valid), 32'd0);
        check("mid_rst_data", 32'(rx_data), 32'h00);
        check("mid_rst_flags", 32'({rx_parity_error, rx_frame_error, rx_overrun}), 32'd0);
        repeat (30) cyc();
        send_frame(8'h5A, 1'b0, 1'b1, -1, 1'b0);
        expect_word("5a_after_rst", 8'h5A, 1'b0, 1'b0, 1'b0);

        for (int n = 0; n < 10; n++) begin
            d    = 8'($urandom_range(0, 255));
            pen  = 1'($urandom_range(0, 1));
            pbit = ($urandom_range(0, 1) == 0) ? even_bit(d) : 1'($urandom_range(0, 1));
            sbit = ($urandom_range(0, 3) != 0);
            flip = ($urandom_range(0, 1) == 1);
            parity_en = pen;
            send_frame(d, pbit, sbit, -1, flip);
            if (!sbit) begin
                repeat (20) cyc();
                rx_uart = 1'b1;
            end
            expect_word($sformatf("rand%0d", n), d, exp_perr(pen, d, pbit), !sbit, 1'b0);
            repeat ($urandom_range(2, 20)) cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_frame_decoder.md
Name: uart_rx_frame_decoder

Overview:
- Standalone UART receive decoder for the frame format our UART transmitters emit.
- Frame is start(0), 8 data bits LSB-first, parity slot, stop(1).
- Oversamples the line, majority-votes each bit at mid-period, checks parity and stop bit, and hands each word to the fabric over a valid/ready interface.
- Sits between the rx_uart pad and any consumer (command parser, FIFO), replacing ad-hoc shift-register receivers.

Parameters:
- OVERSAMPLE, 16, samples per bit period; must be even and >= 8.
- CLKS_PER_SAMPLE, 1, clk cycles per sample tick; bit period = OVERSAMPLE*CLKS_PER_SAMPLE clocks.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous active-high reset
- parity_en  input  1  1 = parity slot carries even parity (^data); 0 = parity slot ignored
- rx_uart  input  1  asynchronous serial line, idle high
- rx_data_valid  output  1  word available; held until accepted
- rx_data_ready  input  1  consumer accepts the word when rx_data_valid is also 1
- rx_data  output  8  received byte
- rx_parity_error  output  1  parity mismatch for the presented word
- rx_frame_error  output  1  stop bit sampled 0 for the presented word
- rx_overrun  output  1  presented word overwrote an unaccepted word

Behaviour:
- Reset:
  - clk and reset are the only clock and reset. Reset is synchronous and active-high, and wins over all other activity, including mid-frame.
  - After reset: state IDLE, all counters 0, synchronizer flops 1.
  - All outputs 0, rx_data = 8'h00.
- Input synchronizer:
  - rx_uart passes through a 2-flop synchronizer before any use.
  - Line-to-decision latency includes these 2 cycles.
- Sample tick:
  - A divider produces a tick once every CLKS_PER_SAMPLE clocks; with CLKS_PER_SAMPLE=1 the tick is high every cycle.
  - The divider free-runs and is cleared on reset and on start-edge detection.
- Bit timing:
  - A sample index 0..OVERSAMPLE-1 advances once per tick within each bit period.
  - Bit value = majority of samples at indices M-1, M and M+1, where M = OVERSAMPLE/2.
  - The bit decision is made at index M+1. The bit period ends at index OVERSAMPLE-1.
- State machine:
  - IDLE: on a synchronized falling edge (previous sample 1, current 0), go to START. Sample index and divider reset to 0. parity_en is latched for the whole frame.
  - START: if the start decision is 1 (glitch), return to IDLE with no output. Otherwise continue to DATA at the end of the period.
  - DATA: 8 bit periods; each decided bit shifts in LSB-first. After bit 7, go to PARITY.
  - PARITY: decide one bit. If latched parity_en=1, parity_error = decided bit XOR (^data); otherwise parity_error = 0.
  - STOP: at the stop decision (index M+1), frame_error = ~decided bit. Deliver the word and return to IDLE immediately, without waiting for the end of the stop period, so back-to-back frames resynchronize on the next falling edge.
  - A frame that ends with stop=0 needs the line to return high before a new falling edge is seen. Edge detection enforces this naturally.
- Output register:
  - rx_data_valid rises the cycle after the stop decision.
  - rx_data, rx_parity_error, rx_frame_error and rx_overrun load in that same cycle and stay stable while valid=1.
  - Handshake: a transfer occurs in a cycle with valid && ready. If no new word loads in that cycle, valid deasserts the next cycle.
  - Overrun: a new word completes while valid=1 and no transfer occurs that cycle. The new word overwrites data and flags, valid stays 1, and rx_overrun=1.
  - Simultaneous events: if a transfer and a new-word load occur in the same cycle, the old word is consumed and the new one loads with rx_overrun=0.
  - rx_overrun clears together with the word it accompanies.
- Glitch rejection: a low pulse shorter than about M samples fails the start decision and produces no output.
- Arithmetic:
  - Counter widths are $clog2 of their maxima.
  - The sample index wraps from OVERSAMPLE-1 to 0 exactly at a bit boundary.
  - The bit counter runs 0..7 and never wraps.

Test Plan:
(All cases use OVERSAMPLE=16 and CLKS_PER_SAMPLE=1, so one bit = 16 clocks.)
- parity_en=1, ready=1, frame 0xA5 with parity 0 and stop 1 -> one-cycle valid, rx_data=0xA5, parity_error=0, frame_error=0, overrun=0.
- parity_en=1, frame 0xA5 with parity slot 1 -> rx_data=0xA5, rx_parity_error=1. Repeat with parity_en=0 -> rx_parity_error=0.
- Frame 0x3C with stop bit 0, line high 32 clocks later -> rx_data=0x3C, rx_frame_error=1. A following good frame 0x81 is received with no errors.
- 4-clock low glitch on an idle line -> no valid, FSM back in IDLE. A 1-clock low glitch at index 8 of data bit 2 in frame 0xFF -> rx_data=0xFF (majority filter).
- ready=0, back-to-back frames 0x11 then 0x22 -> valid held, rx_data=0x22, rx_overrun=1. Assert ready one cycle -> valid=0 next cycle, overrun=0.
- reset for 1 cycle during data bit 3 -> all outputs 0 next cycle. A subsequent full frame 0x5A -> rx_data=0x5A, no errors.
